// File: rtl/alu_ctrl_pkg.sv
// Purpose : shared opcode constants, FSM encoding and opcode helpers for alu_arbiter.
// Latency : n/a (definitions only).
// Backpr. : n/a.
// Contents: OP_* opcode constants, state_t (IDLE/EXEC/WAIT/RESP), opcode class helpers.
package alu_ctrl_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_NOT = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   // Shifts and multiply need a start strobe and a fixed wait.
   function automatic logic is_multicycle(input logic [2:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
   endfunction

   // Only add/sub produce a meaningful ALU flag.
   function automatic logic has_flag(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Purpose : 2-input round-robin arbiter; one-hot grant, pointer favours the side not served last.
// Latency : combinational grant; pointer updates on the clock edge after a grant.
// Backpr. : no grant while en is low; pointer holds.
// Ports   : clk, rst_n, en (arbitration allowed), req[1:0], gnt[1:0] one-hot or zero.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr_q;   // index of the favoured requester
   logic ptr_d;

   always_comb begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
      if (en) begin
         if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
         end else begin
            gnt = req;
         end
      end
      // After serving 0 favour 1, after serving 1 favour 0.
      if (gnt != 2'b00) begin
         ptr_d = gnt[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose : shares one ALU between two valid/ready requesters, one op in flight, tagged response.
// Latency : accept -> rsp_valid is 2 cycles (ops 000..100) or 2+MC_LAT cycles (101/110/111).
// Backpr. : response held until rsp_ready (unbounded); requesters see ready=0 outside IDLE.
// Ports   : r0_*/r1_* request channels, rsp_* response channel, alu_* to/from the ALU.
// Option  : ALU_ARB_STATS_EN adds saturating 16-bit stat_ops0/stat_ops1/stat_busy outputs.
module alu_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int N      = 32,
   parameter int MC_LAT = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         r0_valid,
   output logic         r0_ready,
   input  logic [2:0]   r0_op,
   input  logic [N-1:0] r0_a,
   input  logic [N-1:0] r0_b,
   input  logic         r1_valid,
   output logic         r1_ready,
   input  logic [2:0]   r1_op,
   input  logic [N-1:0] r1_a,
   input  logic [N-1:0] r1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_y,
   output logic [N-1:0] rsp_y_ext,
   output logic         rsp_flg,
   output logic [2:0]   alu_op,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic         alu_inp,
   input  logic [N-1:0] alu_y,
   input  logic [N-1:0] alu_y_ext,
   input  logic         alu_flg
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]  stat_ops0,
   output logic [15:0]  stat_ops1,
   output logic [15:0]  stat_busy
`endif
);

   localparam logic [7:0] MC_LAT_C = 8'(MC_LAT);

   state_t       state_q, state_d;
   logic [2:0]   op_q, op_d;
   logic [N-1:0] a_q, a_d, b_q, b_d;
   logic         id_q, id_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [N-1:0] y_q, y_d, y_ext_q, y_ext_d;
   logic         flg_q, flg_d;

   logic [1:0]   gnt;
   logic         arb_en;
   logic         mc;
   logic         capture;

   // Gated by rst_n so ready stays low while reset is held.
   assign arb_en  = (state_q == IDLE) && rst_n;
   assign mc      = is_multicycle(op_q);
   assign capture = ((state_q == EXEC) && !mc) || ((state_q == WAIT) && (cnt_q == 8'd1));

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (arb_en),
      .req   ({r1_valid, r0_valid}),
      .gnt   (gnt)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (gnt != 2'b00) state_d = EXEC;
         EXEC: state_d = mc ? WAIT : RESP;
         WAIT: if (cnt_q == 8'd1) state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      r0_ready  = gnt[0];
      r1_ready  = gnt[1];
      alu_inp   = (state_q == EXEC) && mc;
      rsp_valid = (state_q == RESP);
   end

   // Request latch, wait counter and result capture.
   always_comb begin
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      y_ext_d = y_ext_q;
      flg_d   = flg_q;
      if (gnt[1]) begin
         op_d = r1_op;
         a_d  = r1_a;
         b_d  = r1_b;
         id_d = 1'b1;
      end else if (gnt[0]) begin
         op_d = r0_op;
         a_d  = r0_a;
         b_d  = r0_b;
         id_d = 1'b0;
      end
      if ((state_q == EXEC) && mc) begin
         cnt_d = MC_LAT_C;
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q - 8'd1;
      end
      if (capture) begin
         y_d     = alu_y;
         // The ALU does not define y_ext/flg outside multiply resp. add/sub.
         y_ext_d = (op_q == OP_MUL) ? alu_y_ext : '0;
         flg_d   = has_flag(op_q) ? alu_flg : 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= 1'b0;
         cnt_q   <= '0;
         y_q     <= '0;
         y_ext_q <= '0;
         flg_q   <= 1'b0;
      end else begin
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         y_ext_q <= y_ext_d;
         flg_q   <= flg_d;
      end
   end

   assign alu_op    = op_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign rsp_id    = id_q;
   assign rsp_y     = y_q;
   assign rsp_y_ext = y_ext_q;
   assign rsp_flg   = flg_q;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] ops0_q, ops0_d, ops1_q, ops1_d, busy_q, busy_d;

   always_comb begin
      ops0_d = ops0_q;
      ops1_d = ops1_q;
      busy_d = busy_q;
      if (gnt[0] && (ops0_q != 16'hFFFF)) ops0_d = ops0_q + 16'd1;
      if (gnt[1] && (ops1_q != 16'hFFFF)) ops1_d = ops1_q + 16'd1;
      if ((state_q != IDLE) && (busy_q != 16'hFFFF)) busy_d = busy_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops0_q <= '0;
         ops1_q <= '0;
         busy_q <= '0;
      end else begin
         ops0_q <= ops0_d;
         ops1_q <= ops1_d;
         busy_q <= busy_d;
      end
   end

   assign stat_ops0 = ops0_q;
   assign stat_ops1 = ops1_q;
   assign stat_busy = busy_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : self-checking bench for alu_arbiter with a behavioural ALU and transaction-level model.
// Latency : n/a.
// Backpr. : drives random and directed rsp_ready stalls.
module tb_alu_arbiter;

   localparam int N      = 32;
   localparam int MC_LAT = 4;

   logic          clk, rst_n;
   logic          r0_valid, r0_ready, r1_valid, r1_ready;
   logic [2:0]    r0_op, r1_op, alu_op;
   logic [N-1:0]  r0_a, r0_b, r1_a, r1_b, alu_a, alu_b;
   logic          rsp_valid, rsp_ready, rsp_id, rsp_flg, alu_inp, alu_flg;
   logic [N-1:0]  rsp_y, rsp_y_ext, alu_y, alu_y_ext;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]   stat_ops0, stat_ops1, stat_busy;
`endif

   alu_arbiter #(.N(N), .MC_LAT(MC_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .rsp_y_ext(rsp_y_ext), .rsp_flg(rsp_flg),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_inp(alu_inp),
      .alu_y(alu_y), .alu_y_ext(alu_y_ext), .alu_flg(alu_flg)
`ifdef ALU_ARB_STATS_EN
      , .stat_ops0(stat_ops0), .stat_ops1(stat_ops1), .stat_busy(stat_busy)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural ALU ----------------
   typedef struct packed {
      logic [N-1:0] y;
      logic [N-1:0] yx;
      logic         f;
   } res_t;

   function automatic res_t alu_true(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      res_t r;
      logic [63:0] p;
      logic [N:0]  s;
      r = '0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r.y = s[N-1:0]; r.f = s[N]; end
         3'd1: begin r.y = a - b; r.f = (a < b); end
         3'd2: r.y = a & b;
         3'd3: r.y = a | b;
         3'd4: r.y = ~a;
         3'd5: r.y = a << b[4:0];
         3'd6: r.y = a >> b[4:0];
         default: begin p = {32'd0, a} * {32'd0, b}; r.y = p[31:0]; r.yx = p[63:32]; end
      endcase
      return r;
   endfunction

   int   mc_cnt;   // edges since the start strobe, -1 when no multi-cycle op started
   res_t tr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          mc_cnt <= -1;
      else if (alu_inp)    mc_cnt <= 0;
      else if (mc_cnt >= 0) mc_cnt <= mc_cnt + 1;
   end

   // Undefined outputs are driven with junk; multi-cycle results are junk until they settle.
   always_comb begin
      tr        = alu_true(alu_op, alu_a, alu_b);
      alu_y     = tr.y;
      alu_y_ext = (alu_op == 3'd7) ? tr.yx : (alu_a ^ 32'hA5A5_0F0F);
      alu_flg   = (alu_op <= 3'd1) ? tr.f : 1'b1;
      if ((alu_op >= 3'd5) && (mc_cnt < MC_LAT - 1)) begin
         alu_y     = ~alu_y;
         alu_y_ext = ~alu_y_ext;
      end
   end

   // ---------------- checking ----------------
   int ncmp = 0, nerr = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transaction-level model state.
   int          cyc = 0, acc_cyc = 0, e_lat = 2, first_vld = -1;
   bit          busy = 0, last_id = 1, acc0 = 0, acc1 = 0, e_mc = 0, e_id = 0, e_f = 0;
   logic [2:0]  e_op;
   logic [N-1:0] e_a, e_b, e_y, e_yx;
   int          nrsp = 0, ninp = 0, nstall = 0, nacc0 = 0, nacc1 = 0, nbusy = 0;
   logic [N-1:0] got_y, got_yx;
   bit          got_id, got_f;
   bit          glog[$];

   task automatic monitor();
      res_t r;
      bit eg0, eg1, exp_rv;
      eg0 = 0; eg1 = 0;
      if (rst_n && !busy) begin
         if (r0_valid && r1_valid) begin
            eg0 = last_id;       // favour the side not served last
            eg1 = !last_id;
         end else begin
            eg0 = r0_valid;
            eg1 = r1_valid;
         end
      end
      chk("r0_ready", r0_ready, eg0);
      chk("r1_ready", r1_ready, eg1);
      acc0 = eg0; acc1 = eg1;
      if (eg0 || eg1) begin
         e_id  = eg1;
         e_op  = eg1 ? r1_op : r0_op;
         e_a   = eg1 ? r1_a : r0_a;
         e_b   = eg1 ? r1_b : r0_b;
         r     = alu_true(e_op, e_a, e_b);
         e_y   = r.y;
         e_yx  = (e_op == 3'd7) ? r.yx : '0;
         e_f   = (e_op <= 3'd1) ? r.f : 1'b0;
         e_mc  = (e_op >= 3'd5);
         e_lat = e_mc ? 2 + MC_LAT : 2;
         acc_cyc = cyc; busy = 1; last_id = eg1; first_vld = -1;
         glog.push_back(eg1);
         if (eg0) nacc0++; else nacc1++;
      end
      chk("alu_inp", alu_inp, busy && e_mc && (cyc == acc_cyc + 1));
      if (alu_inp) ninp++;
      if (busy && cyc > acc_cyc) begin
         chk("alu_op", alu_op, e_op);
         chk("alu_a", alu_a, e_a);
         chk("alu_b", alu_b, e_b);
         nbusy++;
      end
      exp_rv = busy && (cyc >= acc_cyc + e_lat);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (rsp_valid && busy && first_vld < 0) first_vld = cyc - acc_cyc;
      if (exp_rv) begin
         chk("rsp_id", rsp_id, e_id);
         chk("rsp_y", rsp_y, e_y);
         chk("rsp_y_ext", rsp_y_ext, e_yx);
         chk("rsp_flg", rsp_flg, e_f);
         if (rsp_ready) begin
            busy = 0; nrsp++;
            got_y = rsp_y; got_yx = rsp_y_ext; got_id = rsp_id; got_f = rsp_flg;
         end
      end
      if (rsp_valid && !rsp_ready) nstall++;
   endtask

   // Sample just after the drive point, then move to the next negedge.
   task automatic tick();
      #1;
      monitor();
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_until_rsp(input int limit);
      int n0, k;
      n0 = nrsp; k = 0;
      while (nrsp == n0 && k < limit) begin
         tick();
         if (acc0) r0_valid = 0;
         if (acc1) r1_valid = 0;
         k++;
      end
      chk("rsp_timeout", nrsp != n0, 1);
   endtask

   task automatic drain(input int limit);
      int k;
      k = 0;
      r0_valid = 0; r1_valid = 0; rsp_ready = 1;
      while (busy && k < limit) begin tick(); k++; end
      chk("drain_timeout", busy, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {r0_ready, r1_ready, rsp_valid, rsp_id, rsp_flg, alu_inp, alu_op}, 0);
      chk({tag, "_dat"}, {rsp_y, rsp_y_ext}, 0);
      chk({tag, "_alu"}, {alu_a, alu_b}, 0);
   endtask

   task automatic model_reset();
      busy = 0; last_id = 1; nacc0 = 0; nacc1 = 0; nbusy = 0;
   endtask

   initial begin
      int k, n0, s0;
      rst_n = 1; rsp_ready = 0;
      r0_valid = 0; r0_op = 0; r0_a = 0; r0_b = 0;
      r1_valid = 0; r1_op = 0; r1_a = 0; r1_b = 0;
      #1 rst_n = 0;
      r0_valid = 1; r1_valid = 1;
      #2;
      chk_all_zero("reset");
      r0_valid = 0; r1_valid = 0;
      @(negedge clk);
      rst_n = 1;
      model_reset();

      // r0 add 5+7
      r0_valid = 1; r0_op = 3'd0; r0_a = 5; r0_b = 7; rsp_ready = 1;
      run_until_rsp(20);
      chk("t1_y", got_y, 12);
      chk("t1_id", got_id, 0);
      chk("t1_yx", got_yx, 0);
      chk("t1_lat", first_vld, 2);

      // r1 multiply 0x10000 * 0x10000
      n0 = ninp;
      r1_valid = 1; r1_op = 3'd7; r1_a = 32'h10000; r1_b = 32'h10000;
      run_until_rsp(30);
      chk("t3_inp_pulses", ninp - n0, 1);
      chk("t3_y", got_y, 0);
      chk("t3_yx", got_yx, 1);
      chk("t3_id", got_id, 1);
      chk("t3_lat", first_vld, 2 + MC_LAT);

      // both valid continuously: alternating grants
      glog.delete();
      r0_valid = 1; r0_op = 0; r0_a = $urandom; r0_b = $urandom;
      r1_valid = 1; r1_op = 0; r1_a = $urandom; r1_b = $urandom;
      k = 0;
      while (glog.size() < 4 && k < 40) begin
         tick();
         if (acc0) begin r0_a = $urandom; r0_b = $urandom; end
         if (acc1) begin r1_a = $urandom; r1_b = $urandom; end
         k++;
      end
      drain(20);
      chk("t2_ngrants", glog.size() >= 4, 1);
      for (int i = 0; i < 4; i++) chk("t2_order", (i < glog.size()) ? 32'(glog[i]) : 32'd2, i % 2);

      // back-pressure: response held 10 cycles, r1 waits
      r0_valid = 1; r0_op = 3'd3; r0_a = $urandom; r0_b = $urandom; rsp_ready = 0;
      tick();
      chk("t4_acc", acc0, 1);
      r0_valid = 0;
      r1_valid = 1; r1_op = 3'd0; r1_a = 1; r1_b = 2;
      k = 0;
      while (!(busy && first_vld >= 0) && k < 20) begin tick(); k++; end
      s0 = nstall;
      repeat (10) tick();
      chk("t4_stall", nstall - s0, 10);
      rsp_ready = 1;
      run_until_rsp(5);
      chk("t4_id", got_id, 0);
      run_until_rsp(20);
      chk("t4_id_next", got_id, 1);

      // reset while waiting on a multiply
      r0_valid = 1; r0_op = 3'd7; r0_a = $urandom; r0_b = $urandom;
      tick();
      r0_valid = 0;
      k = 0;
      while (cyc <= acc_cyc + 2 && k < 10) begin tick(); k++; end
      rst_n = 0; r1_valid = 1;
      #1;
      chk_all_zero("mid_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1; r1_valid = 0;
      n0 = nrsp;
      repeat (10) tick();
      chk("no_stale_rsp", nrsp - n0, 0);
      glog.delete();
      r0_valid = 1; r0_op = 3'd0; r0_a = 9; r0_b = 1;
      r1_valid = 1; r1_op = 3'd2; r1_a = 3; r1_b = 6;
      tick();
      r0_valid = acc0 ? 1'b0 : r0_valid;
      chk("t5_first_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'd2, 0);
      run_until_rsp(20);
      chk("t5_y", got_y, 10);
      drain(20);

      // sub flag is passed, and flag forced low for AND
      r0_valid = 1; r0_op = 3'd1; r0_a = 3; r0_b = 5;
      run_until_rsp(20);
      chk("t6_y", got_y, 32'hFFFF_FFFE);
      chk("t6_flg", got_f, 1);
      r1_valid = 1; r1_op = 3'd2; r1_a = 32'hF0F0; r1_b = 32'hFF00;
      run_until_rsp(20);
      chk("t6_and_y", got_y, 32'hF000);
      chk("t6_and_flg", got_f, 0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (!r0_valid || acc0) begin
            r0_valid = $urandom_range(0, 1); r0_op = 3'($urandom); r0_a = $urandom; r0_b = $urandom;
         end else if ($urandom_range(0, 7) == 0) r0_valid = 0;
         if (!r1_valid || acc1) begin
            r1_valid = $urandom_range(0, 1); r1_op = 3'($urandom); r1_a = $urandom; r1_b = $urandom;
         end else if ($urandom_range(0, 7) == 0) r1_valid = 0;
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain(40);
      chk("rand_rsp_seen", nrsp > 20, 1);

`ifdef ALU_ARB_STATS_EN
      #1;
      chk("stat_ops0", stat_ops0, nacc0);
      chk("stat_ops1", stat_ops1, nacc1);
      chk("stat_busy", stat_busy, nbusy);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name:
alu_arbiter

Overview:
- Shares one alu instance (N-bit add/sub/and/or/not/shift/multiply datapath) between two requesters, each using a valid/ready handshake.
- Round-robin grant; one operation in flight at a time.
- Drives the ALU operands, opcode and multi-cycle start strobe. Captures y/y_ext/flg and returns them on a single response channel tagged with the requester id.

Parameters:
- N, 32: operand/result width; must match the attached alu.
- MC_LAT, 4: cycles to wait after the start strobe for opcodes 101, 110 and 111 (shift/multiply); legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_valid  in  1  requester 0 has an op
- r0_ready  out  1  requester 0 op accepted this cycle
- r0_op  in  3  requester 0 opcode
- r0_a  in  N  requester 0 operand a
- r0_b  in  N  requester 0 operand b
- r1_valid  in  1  requester 1 has an op
- r1_ready  out  1  requester 1 op accepted this cycle
- r1_op  in  3  requester 1 opcode
- r1_a  in  N  requester 1 operand a
- r1_b  in  N  requester 1 operand b
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that issued the op
- rsp_y  out  N  low result
- rsp_y_ext  out  N  high product half (zero for non-multiply ops)
- rsp_flg  out  1  ALU flag
- alu_op  out  3  to alu op
- alu_a  out  N  to alu a
- alu_b  out  N  to alu b
- alu_inp  out  1  to alu inp; one-cycle start strobe
- alu_y  in  N  from alu y
- alu_y_ext  in  N  from alu y_ext
- alu_flg  in  1  from alu flg

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, grant pointer = 0, all outputs 0. Reset mid-operation abandons the op; no response is produced.
- IDLE:
  - If any rX_valid, grant per round-robin: the pointer favours the requester not served last; with a single valid, it is granted.
  - Grant asserts rX_ready for exactly that cycle.
  - Latch op/a/b/id into registers, advance the pointer, go to EXEC.
  - r0_ready and r1_ready are never both high.
- EXEC (1 cycle):
  - alu_op/alu_a/alu_b are driven from the latched registers and held stable until RESP is left.
  - Opcodes 000..100: capture alu_y/y_ext/flg at the end of the cycle, go to RESP.
  - Opcodes 101/110/111: alu_inp = 1 this cycle only, load counter = MC_LAT, go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, capture the results and go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE, and a new grant is possible on the next cycle.
  - Back-pressure is unlimited.
- Latency, accept to rsp_valid: 2 cycles for single-cycle ops; 2 + MC_LAT cycles for multi-cycle ops.
- Flag rules:
  - rsp_flg is captured as-is for 000/001.
  - rsp_flg is forced to 0 for all other ops; the ALU does not drive flg for those.
- rsp_y_ext is captured only for 111; otherwise it is 0.
- Requests arriving while not in IDLE see ready = 0. A requester may drop valid before acceptance.

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - Adds outputs stat_ops0 and stat_ops1 (16-bit each): counts of accepted ops per requester.
  - Adds output stat_busy (16-bit): counts cycles spent outside IDLE.
  - All counters saturate at 0xFFFF and are cleared by rst_n.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package alu_ctrl_pkg:
  - opcode constants OP_ADD=000 … OP_MUL=111
  - state encoding IDLE/EXEC/WAIT/RESP
  - function is_multicycle(op)
- Sub-module rr_arb2 (2-input round-robin arbiter with pointer register, enable input, one-hot grant output), instantiated once.

Test Plan:
- r0 only, op=000, a=5, b=7 -> r0_ready for 1 cycle; rsp_valid 2 cycles later; rsp_y=12, rsp_id=0, rsp_y_ext=0.
- Both valid continuously, ops 000 → grants alternate r0, r1, r0, r1. Check no double ready and rsp_id matching each op.
- r1 op=111, a=0x10000, b=0x10000, MC_LAT=4 -> alu_inp pulses exactly once; rsp_valid at cycle 6; rsp_y_ext=1, rsp_y=0.
- rsp_ready held low for 10 cycles after rsp_valid -> rsp_* stable; r0_ready and r1_ready stay 0 throughout.
- rst_n asserted during WAIT -> outputs 0 immediately; no response after release; next request is served normally with grant pointer at 0.
- op=001, a=3, b=5 -> rsp_y=0xFFFFFFFE; rsp_flg equals alu_flg. op=010 -> rsp_flg=0.
